// File: rtl/pe_pkg.sv
// Shared constants and types for the PE output path: vector sizing, accumulator width and drain FSM states.
package pe_pkg;

    localparam int unsigned DATA_W  = 16;
    localparam int unsigned N_CH    = 32;
    localparam int unsigned ACC_W   = 24;
    localparam int unsigned PASS_W  = 6;
    localparam int unsigned SHIFT_W = 4;
    localparam int unsigned N_VEC   = 3 * N_CH;
    localparam int unsigned IDX_W   = $clog2(N_VEC);

    typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_DRAIN} acc_state_t;

    typedef logic signed [DATA_W-1:0] feat_t;
    typedef logic signed [ACC_W-1:0]  acc_t;

endpackage

// File: rtl/psum_requant.sv
// Requantizes one accumulator to DATA_W: arithmetic right shift with round-half-up, then saturation.
// Define PSUM_RELU_EN to clamp negative results to zero after saturation.
module psum_requant
    import pe_pkg::*;
(
    input  acc_t               i_acc,
    input  logic [SHIFT_W-1:0] i_shift,
    output feat_t              o_data_c
);

    localparam int unsigned EXT_W = ACC_W + 1;
    localparam logic signed [EXT_W-1:0] SAT_MAX = {{(EXT_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [EXT_W-1:0] SAT_MIN = {{(EXT_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

    logic signed [EXT_W-1:0] ext;
    logic signed [EXT_W-1:0] half;
    logic signed [EXT_W-1:0] shifted;

    // One guard bit keeps the rounding add from overflowing before the shift.
    always_comb begin
        ext  = {i_acc[ACC_W-1], i_acc};
        half = '0;
        if (i_shift != '0) begin
            half = EXT_W'(1) << (i_shift - SHIFT_W'(1));
        end
        shifted = (ext + half) >>> i_shift;

        if (shifted > SAT_MAX) begin
            o_data_c = {1'b0, {(DATA_W-1){1'b1}}};
        end else if (shifted < SAT_MIN) begin
            o_data_c = {1'b1, {(DATA_W-1){1'b0}}};
        end else begin
            o_data_c = shifted[DATA_W-1:0];
        end
`ifdef PSUM_RELU_EN
        if (o_data_c[DATA_W-1]) begin
            o_data_c = '0;
        end
`endif
    end

endmodule

// File: rtl/psum_accumulator.sv
// Accumulates PE output-feature vectors over several runs, then streams requantized elements out.
// Define PSUM_RELU_EN to clamp streamed results at zero.
module psum_accumulator
    import pe_pkg::*;
(
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_start,
    input  logic [PASS_W-1:0]        i_cfg_passes,
    input  logic [SHIFT_W-1:0]       i_cfg_shift,
    input  logic                     i_pe_finish,
    input  feat_t [N_VEC-1:0]        i_pe_feature,
    output logic                     o_pe_ack,
    output logic                     o_busy,
    output logic                     o_out_valid,
    input  logic                     i_out_ready,
    output feat_t                    o_out_data,
    output logic [IDX_W-1:0]         o_out_idx,
    output logic                     o_done
);

    acc_state_t         state;
    acc_t               acc     [N_VEC];
    acc_t               acc_sum [N_VEC];
    logic [PASS_W-1:0]  passes;
    logic [PASS_W-1:0]  cnt;
    logic [SHIFT_W-1:0] shift;
    logic               finish_q;

    logic               pe_event_c;
    logic               last_pass_c;
    logic               handshake_c;
    logic [IDX_W-1:0]   idx_nxt_c;
    acc_t               req_in_c;
    feat_t              req_out_c;

    // Next element to present: the fresh sum of element 0 on entering drain, else the following index.
    always_comb begin
        pe_event_c  = i_pe_finish & ~finish_q;
        last_pass_c = (cnt + PASS_W'(1)) == passes;
        handshake_c = o_out_valid & i_out_ready;
        idx_nxt_c   = (o_out_idx == IDX_W'(N_VEC-1)) ? '0 : o_out_idx + IDX_W'(1);
        for (int i = 0; i < N_VEC; i++) begin
            acc_sum[i] = acc[i] + {{(ACC_W-DATA_W){i_pe_feature[i][DATA_W-1]}}, i_pe_feature[i]};
        end
        req_in_c = (state == S_ACCUM) ? acc_sum[0] : acc[idx_nxt_c];
    end

    psum_requant u_requant (
        .i_acc    (req_in_c),
        .i_shift  (shift),
        .o_data_c (req_out_c)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state       <= S_IDLE;
            finish_q    <= 1'b0;
            passes      <= '0;
            cnt         <= '0;
            shift       <= '0;
            o_pe_ack    <= 1'b0;
            o_busy      <= 1'b0;
            o_out_valid <= 1'b0;
            o_out_data  <= '0;
            o_out_idx   <= '0;
            o_done      <= 1'b0;
            for (int i = 0; i < N_VEC; i++) begin
                acc[i] <= '0;
            end
        end else begin
            finish_q <= i_pe_finish;
            o_pe_ack <= 1'b0;
            o_done   <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (i_start) begin
                        passes <= (i_cfg_passes == '0) ? PASS_W'(1) : i_cfg_passes;
                        shift  <= i_cfg_shift;
                        cnt    <= '0;
                        o_busy <= 1'b1;
                        state  <= S_ACCUM;
                        for (int i = 0; i < N_VEC; i++) begin
                            acc[i] <= '0;
                        end
                    end
                end
                S_ACCUM: begin
                    if (pe_event_c) begin
                        for (int i = 0; i < N_VEC; i++) begin
                            acc[i] <= acc_sum[i];
                        end
                        o_pe_ack <= 1'b1;
                        cnt      <= cnt + PASS_W'(1);
                        if (last_pass_c) begin
                            state       <= S_DRAIN;
                            o_out_valid <= 1'b1;
                            o_out_idx   <= '0;
                            o_out_data  <= req_out_c;
                        end
                    end
                end
                S_DRAIN: begin
                    if (handshake_c) begin
                        if (o_out_idx == IDX_W'(N_VEC-1)) begin
                            state       <= S_IDLE;
                            o_out_valid <= 1'b0;
                            o_busy      <= 1'b0;
                            o_done      <= 1'b1;
                            o_out_idx   <= '0;
                        end else begin
                            o_out_idx  <= idx_nxt_c;
                            o_out_data <= req_out_c;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_psum_accumulator.sv
// Directed and randomized checks of psum_accumulator against an arithmetic reference model.
module tb_psum_accumulator;
    import pe_pkg::*;

    logic               clk = 1'b0;
    logic               rst;
    logic               start;
    logic [PASS_W-1:0]  cfg_passes;
    logic [SHIFT_W-1:0] cfg_shift;
    logic               pe_finish;
    feat_t [N_VEC-1:0]  pe_feature;
    logic               pe_ack;
    logic               busy;
    logic               out_valid;
    logic               out_ready;
    feat_t              out_data;
    logic [IDX_W-1:0]   out_idx;
    logic               done;

    int     checks   = 0;
    int     failures = 0;
    longint macc [N_VEC];
    int     cur_shift;
    int     cur_passes;
    int     runs_done;

    always #5 clk = ~clk;

    psum_accumulator dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_start      (start),
        .i_cfg_passes (cfg_passes),
        .i_cfg_shift  (cfg_shift),
        .i_pe_finish  (pe_finish),
        .i_pe_feature (pe_feature),
        .o_pe_ack     (pe_ack),
        .o_busy       (busy),
        .o_out_valid  (out_valid),
        .i_out_ready  (out_ready),
        .o_out_data   (out_data),
        .o_out_idx    (out_idx),
        .o_done       (done)
    );

    task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Two's-complement wrap of an arbitrary integer into ACC_W bits.
    function automatic longint wrap_acc(input longint x);
        longint span = longint'(1) << ACC_W;
        longint r = x % span;
        if (r < 0) r += span;
        if (r >= span / 2) r -= span;
        return r;
    endfunction

    // floor(a / 2^s + 1/2), clamped to the DATA_W signed range.
    function automatic longint ref_q(input longint a, input int s);
        longint d   = longint'(1) << s;
        longint x   = a + ((s > 0) ? d / 2 : 0);
        longint q   = x / d;
        longint lim = longint'(1) << (DATA_W - 1);
        if ((x % d) != 0 && x < 0) q -= 1;
        if (q > lim - 1) q = lim - 1;
        if (q < -lim) q = -lim;
`ifdef PSUM_RELU_EN
        if (q < 0) q = 0;
`endif
        return q;
    endfunction

    task automatic start_tile(input int passes, input int shift, input bit finish_edge);
        @(negedge clk);
        start      = 1'b1;
        cfg_passes = PASS_W'(passes);
        cfg_shift  = SHIFT_W'(shift);
        if (finish_edge) pe_finish = 1'b1;
        cur_shift  = shift;
        cur_passes = (passes == 0) ? 1 : passes;
        runs_done  = 0;
        for (int i = 0; i < N_VEC; i++) macc[i] = 0;
        @(negedge clk);
        start = 1'b0;
        check("busy_after_start", busy, 1);
        check("no_ack_at_start", pe_ack, 0);
        if (finish_edge) begin
            pe_finish = 1'b0;
            @(negedge clk);
            check("start_edge_not_counted", pe_ack, 0);
        end
    endtask

    // kind: 0 -> i-48, 1 -> constant val, 2 -> random, 3 -> random with rounding corner values up front
    task automatic pe_run(input int kind, input int val);
        feat_t f;
        @(negedge clk);
        for (int i = 0; i < N_VEC; i++) begin
            case (kind)
                0:       f = DATA_W'(i - 48);
                1:       f = DATA_W'(val);
                default: f = DATA_W'($urandom);
            endcase
            if (kind == 3 && i == 0) f = -16'sd5;
            if (kind == 3 && i == 1) f = 16'sd5;
            if (kind == 3 && i == 2) f = 16'sd7;
            pe_feature[i] = f;
            macc[i] = wrap_acc(macc[i] + longint'(f));
        end
        pe_finish = 1'b1;
        runs_done++;
        @(negedge clk);
        check("ack_pulse", pe_ack, 1);
        check("valid_after_run", out_valid, (runs_done == cur_passes) ? 1 : 0);
        pe_finish = 1'b0;
        @(negedge clk);
        check("ack_one_cycle", pe_ack, 0);
    endtask

    // rmode: 0 ready tied high, 1 toggled 1010..., 2 random stalls
    task automatic drain(input int rmode, input int abort_at, input bit extra_rises);
        int                 hs      = 0;
        bit                 stalled = 1'b0;
        bit                 fin     = 1'b0;
        bit                 r;
        feat_t              sd      = '0;
        logic [IDX_W-1:0]   si      = '0;
        for (int cyc = 0; cyc < 2000 && !fin; cyc++) begin
            @(negedge clk);
            if (abort_at >= 0 && hs == abort_at) begin
                check("abort_idx", out_idx, abort_at);
                rst = 1'b1;
                out_ready = 1'b0;
                @(negedge clk);
                check("abort_valid", out_valid, 0);
                check("abort_busy", busy, 0);
                check("abort_done", done, 0);
                rst = 1'b0;
                @(negedge clk);
                check("abort_no_done", done, 0);
                fin = 1'b1;
            end else if (!out_valid) begin
                check("done_after_last", done, 1);
                check("handshake_count", hs, N_VEC);
                check("idle_busy", busy, 0);
                fin = 1'b1;
                @(negedge clk);
                check("done_single_pulse", done, 0);
            end else begin
                if (stalled) begin
                    check("stall_data", out_data, sd);
                    check("stall_idx", out_idx, si);
                end
                check("no_ack_in_drain", pe_ack, 0);
                check("busy_in_drain", busy, 1);
                case (rmode)
                    0:       r = 1'b1;
                    1:       r = (cyc % 2) == 0;
                    default: r = ($urandom % 3) != 0;
                endcase
                if (extra_rises) pe_finish = (cyc == 5 || cyc == 30);
                out_ready = r;
                if (r) begin
                    check("out_idx", out_idx, hs);
                    check("out_data", out_data, ref_q(macc[hs], cur_shift));
                    hs++;
                    stalled = 1'b0;
                end else begin
                    stalled = 1'b1;
                    sd = out_data;
                    si = out_idx;
                end
            end
        end
        if (!fin) check("drain_timeout", 0, 1);
        out_ready = 1'b0;
        pe_finish = 1'b0;
    endtask

    initial begin
        rst        = 1'b1;
        start      = 1'b0;
        pe_finish  = 1'b0;
        out_ready  = 1'b0;
        cfg_passes = '0;
        cfg_shift  = '0;
        pe_feature = '0;
        cur_shift  = 0;
        cur_passes = 1;
        runs_done  = 0;
        repeat (3) @(negedge clk);
        check("rst_ack", pe_ack, 0);
        check("rst_busy", busy, 0);
        check("rst_valid", out_valid, 0);
        check("rst_done", done, 0);
        check("rst_idx", out_idx, 0);
        check("rst_data", out_data, 0);
        rst = 1'b0;

        // Ramp features, single pass, no shift.
        start_tile(1, 0, 1'b0);
        pe_run(0, 0);
        drain(0, -1, 1'b0);

        // Three passes of 1000 with shift 2; extra finish rises during drain are ignored.
        start_tile(3, 2, 1'b0);
        repeat (3) pe_run(1, 1000);
        drain(0, -1, 1'b1);

        // Saturation in both directions.
        start_tile(4, 0, 1'b0);
        repeat (4) pe_run(1, 30000);
        drain(0, -1, 1'b0);
        start_tile(4, 0, 1'b0);
        repeat (4) pe_run(1, -30000);
        drain(0, -1, 1'b0);

        // Rounding corners.
        start_tile(1, 1, 1'b0);
        pe_run(3, 0);
        drain(1, -1, 1'b0);
        start_tile(1, 3, 1'b0);
        pe_run(3, 0);
        drain(0, -1, 1'b0);

        // Backpressure, plus a finish edge coinciding with start.
        start_tile(2, 5, 1'b1);
        repeat (2) pe_run(2, 0);
        drain(1, -1, 1'b0);
        start_tile(0, 4, 1'b0);
        pe_run(2, 0);
        drain(2, -1, 1'b0);

        // Reset mid-drain, then a fresh tile.
        start_tile(2, 3, 1'b0);
        repeat (2) pe_run(2, 0);
        drain(2, 40, 1'b0);
        start_tile(1, 3, 1'b0);
        pe_run(2, 0);
        drain(0, -1, 1'b0);

        // Random configurations.
        for (int t = 0; t < 3; t++) begin
            int np = int'($urandom_range(1, 5));
            start_tile(np, int'($urandom_range(0, 15)), 1'b0);
            repeat (np) pe_run(2, 0);
            drain(2, -1, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
